// File: rtl/sd_pkg.sv
// sd_pkg: constants and types shared by the SD host command path
// (command transmitter and response receiver).
//   SD_CMD_FRAME_LEN : bits in one command token (start .. end bit)
//   SD_CMD_HDR_LEN   : bits covered by the CRC7 (start, tx, index, argument)
//   SD_CRC7_POLY     : CRC7 generator x^7 + x^3 + 1 with the x^7 term implied
//   sd_cmd_state_t   : transmitter FSM states
//   CMDxx            : command index constants
//   crc7_step        : one serial CRC7 update
package sd_pkg;

  localparam int SD_CMD_FRAME_LEN = 48;
  localparam int SD_CMD_HDR_LEN   = 40;
  localparam logic [6:0] SD_CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_COMPLETE,
    S_GAP
  } sd_cmd_state_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD9   = 6'd9;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7 + x^3 + 1), MSB of the message first.
//   clk : SD bus clock
//   rst : synchronous active-high reset
//   clr : clears the register (wins over en)
//   en  : shift din into the CRC this cycle
//   din : message bit
//   crc : current remainder
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_cmd_send.sv
// sd_cmd_send: SD CMD-line token transmitter. Frames {start, tx, index,
// argument, CRC7, end} and shifts it out MSB-first, one bit per clk, driving
// the open CMD line only while a token is in flight, then enforces an idle
// gap of NCC_CYCLES before the next token may be accepted.
//   NCC_CYCLES : minimum idle cycles between Complete falling and next accept
//   clk        : SD bus clock
//   rst        : synchronous active-high reset
//   Enable     : level request, hold until Complete
//   Command    : command index, latched at acceptance
//   Argument   : command argument, latched at acceptance
//   cmd        : SD CMD line (driven while Sending, else z)
//   Sending    : output enable for cmd
//   Complete   : token sent, held while Enable stays high
//
// state      | meaning
// S_IDLE     | line released, waiting for Enable
// S_SEND     | shifting the 48-bit token, bit_cnt = bit currently on the line
// S_COMPLETE | token done; Complete follows Enable until Enable drops
// S_GAP      | enforced idle gap, Enable ignored
module sd_cmd_send
  import sd_pkg::*;
#(
  parameter int unsigned NCC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Enable,
  input  logic [5:0]  Command,
  input  logic [31:0] Argument,
  inout  wire         cmd,
  output logic        Sending,
  output logic        Complete
);

  localparam int GAP_W = $clog2(NCC_CYCLES + 2);
  localparam logic [5:0] LAST_BIT = 6'(SD_CMD_FRAME_LEN - 1);
  localparam logic [5:0] HDR_LEN  = 6'(SD_CMD_HDR_LEN);

  sd_cmd_state_t state, state_nxt;

  logic [39:0]      frame, frame_nxt;
  logic [5:0]       bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             cmd_out, cmd_out_nxt;
  logic             sending, sending_nxt;
  logic             complete, complete_nxt;

  logic [5:0] bit_idx;
  logic       tx_bit;
  logic       crc_clr, crc_en;
  logic [6:0] crc;

  // The CRC is fed each header bit on the edge that loads it onto the line.
  // Bit 0 (start bit) is always 0, and shifting a 0 into a cleared CRC leaves
  // it at 0, so clearing at acceptance is equivalent to clearing then feeding
  // bit 0. The remainder is thus final as soon as bit 39 is loaded, in time
  // for bit 40 to carry crc[6].
  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (tx_bit),
    .crc (crc)
  );

  assign bit_idx = bit_cnt + 6'd1;

  always_comb begin
    tx_bit = 1'b1;
    if (bit_idx < HDR_LEN) begin
      tx_bit = frame[6'd39 - bit_idx];
    end else if (bit_idx < LAST_BIT) begin
      tx_bit = crc[3'(6'd46 - bit_idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      cmd_out  <= 1'b1;
      sending  <= 1'b0;
      complete <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame    <= frame_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      cmd_out  <= cmd_out_nxt;
      sending  <= sending_nxt;
      complete <= complete_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    cmd_out_nxt  = cmd_out;
    sending_nxt  = sending;
    complete_nxt = complete;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    unique case (state)
      S_IDLE: begin
        sending_nxt  = 1'b0;
        complete_nxt = 1'b0;
        if (Enable) begin
          frame_nxt   = {2'b01, Command, Argument};
          bit_cnt_nxt = '0;
          cmd_out_nxt = 1'b0;
          sending_nxt = 1'b1;
          crc_clr     = 1'b1;
          state_nxt   = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt == LAST_BIT) begin
          sending_nxt = 1'b0;
          cmd_out_nxt = 1'b1;
          state_nxt   = S_COMPLETE;
        end else begin
          bit_cnt_nxt = bit_idx;
          cmd_out_nxt = tx_bit;
          crc_en      = (bit_idx < HDR_LEN);
        end
      end
      S_COMPLETE: begin
        sending_nxt = 1'b0;
        if (Enable) begin
          complete_nxt = 1'b1;
        end else begin
          complete_nxt = 1'b0;
          gap_cnt_nxt  = GAP_W'(NCC_CYCLES);
          state_nxt    = S_GAP;
        end
      end
      S_GAP: begin
        // Leaving on the count-to-1 edge puts the next possible acceptance
        // exactly NCC_CYCLES+1 edges after Complete fell.
        if (gap_cnt <= GAP_W'(1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd      = sending ? cmd_out : 1'bz;
  assign Sending  = sending;
  assign Complete = complete;

endmodule
